// File: rtl/keygen_mq_montyred.sv
// Four-stage pipelined Montgomery reducer: dout = din * 2^-16 mod Q, canonical in [0, Q).
// Optional input range checker enabled by defining KEYGEN_MQ_RED_RANGE_CHK_EN.
module keygen_mq_montyred #(
   parameter int Q          = 12289,
   parameter int Q0I        = 12287,
   parameter int DIN_WIDTH  = 32,
   parameter int DOUT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DIN_WIDTH-1:0]  din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  range_err
);

   localparam int ZW = DIN_WIDTH + 1;   // z + t without truncation
   localparam int SW = ZW - 16;         // s = (z + t) >> 16
   localparam int RW = SW + 1;          // signed room for s - Q
   localparam logic [15:0] Q0I_W = 16'(Q0I);
   localparam logic [15:0] Q_W   = 16'(Q);

   logic                  s1_valid, s2_valid, s3_valid, s4_valid;
   logic [DIN_WIDTH-1:0]  s1_z, s2_z;
   logic [15:0]           s1_m, m_next;
   logic [30:0]           s2_t, t_next;
   logic [ZW-1:0]         sum_zt;
   logic [SW-1:0]         s3_s, s_next;
   logic signed [RW-1:0]  r_diff, r_fix;
   logic [DOUT_WIDTH-1:0] s4_r;
   logic                  adv;

   // Handshake: a word moves on either port only in a cycle where valid and
   // ready are both high; the whole pipe advances together when S4 is empty
   // or being drained, otherwise every stage holds.
   assign adv        = !s4_valid || dout_ready;
   assign din_ready  = adv && !reset;
   assign dout       = s4_r;
   assign dout_valid = s4_valid && !reset;

   always_comb begin
      m_next = din[15:0] * Q0I_W;
      t_next = 31'(s1_m) * 31'(Q_W);
      sum_zt = ZW'(s2_z) + ZW'(s2_t);
      s_next = SW'(sum_zt >> 16);
      r_diff = $signed({1'b0, s3_s}) - $signed(RW'(Q_W));
      r_fix  = r_diff;
      if (r_diff[RW-1])
         r_fix = r_diff + $signed(RW'(Q_W));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s4_valid <= 1'b0;
         s4_r     <= '0;
      end else if (adv) begin
         s1_valid <= din_valid;
         s1_z     <= din;
         s1_m     <= m_next;
         s2_valid <= s1_valid;
         s2_z     <= s1_z;
         s2_t     <= t_next;
         s3_valid <= s2_valid;
         s3_s     <= s_next;
         s4_valid <= s3_valid;
         s4_r     <= DOUT_WIDTH'(r_fix);
      end
   end

`ifdef KEYGEN_MQ_RED_RANGE_CHK_EN
   localparam logic [ZW-1:0] Z_LIMIT = ZW'(Q) << 16;
   logic range_err_q;

   always_ff @(posedge clk) begin
      if (reset)
         range_err_q <= 1'b0;
      else if (din_valid && din_ready && (ZW'(din) >= Z_LIMIT))
         range_err_q <= 1'b1;
   end

   assign range_err = range_err_q;
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_keygen_mq_montyred.sv
// Self-checking bench for keygen_mq_montyred: vector table, random stream vs.
// modular-arithmetic model, backpressure, reset flush and range flag.
module tb_keygen_mq_montyred;

   localparam int Q = 12289;

   typedef struct {
      logic [31:0] z;
      logic [15:0] e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        range_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rinv   = 0;
   int bp_ph  = 0;
   bit lat_chk = 1'b0;
   bit bp_mode = 1'b0;
   bit mon_en  = 1'b0;

   // bit 16 marks an item whose value is unspecified (range violation)
   logic [16:0] exp_q[$];
   int          acc_q[$];
   logic [16:0] mon_e;
   int          mon_a;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_dout  = '0;
   vec_t        vecs[5];

   keygen_mq_montyred dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .range_err  (range_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // z * R^-1 mod Q with R = 2^16, from plain modular arithmetic
   function automatic logic [15:0] model(input logic [31:0] z);
      longint v;
      v = ((longint'(z) % Q) * rinv) % Q;
      return v[15:0];
   endfunction

   // Output-side monitor: all signals are stable at the falling edge and
   // describe the transfers that the next rising edge will perform.
   always @(negedge clk) begin
      if (mon_en) begin
         if (reset) begin
            check("din_ready_in_reset", din_ready, 0);
            check("dout_valid_in_reset", dout_valid, 0);
            exp_q.delete();
            acc_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid_held", dout_valid, 1);
               check("stall_dout_held", dout, prev_dout);
            end
            check("din_ready_rule", din_ready, !(dout_valid && !dout_ready));
            if (dout_valid && dout_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output: got %0d with no item pending (cycle %0d)", dout, cyc);
               end else begin
                  mon_e = exp_q.pop_front();
                  mon_a = acc_q.pop_front();
                  if (!mon_e[16]) begin
                     check("dout_value", dout, mon_e[15:0]);
                     check("dout_below_q", dout < Q, 1);
                  end
                  if (lat_chk) check("latency", cyc - mon_a, 4);
               end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
         end
      end
   end

   initial begin
      dout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            dout_ready = (bp_ph == 0);
            bp_ph = (bp_ph + 1) % 4;
         end else begin
            dout_ready = 1'b1;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] z, input logic [16:0] e);
      int n = 0;
      din       = z;
      din_valid = 1'b1;
      @(negedge clk);
      while (!din_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!din_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got din_ready 0 for %0d cycles expected 1", n);
      end else begin
         exp_q.push_back(e);
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      din_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] z;
      bit          chk_en;
`ifdef KEYGEN_MQ_RED_RANGE_CHK_EN
      chk_en = 1'b1;
`else
      chk_en = 1'b0;
`endif
      for (int i = 1; i < Q; i++)
         if ((longint'(i) * 65536) % Q == 1) rinv = i;

      vecs[0] = '{z: 32'd327680,    e: 16'd5};
      vecs[1] = '{z: 32'd16736281,  e: 16'd4091};
      vecs[2] = '{z: 32'd12289,     e: 16'd0};
      vecs[3] = '{z: 32'd0,         e: 16'd0};
      vecs[4] = '{z: 32'd805306368, e: 16'd12288};

      reset     = 1'b1;
      din       = '0;
      din_valid = 1'b0;
      mon_en    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_dout_valid", dout_valid, 0);
      check("post_reset_range_err", range_err, 0);
      check("post_reset_din_ready", din_ready, 1);
      @(posedge clk);
      #1;

      lat_chk = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(vecs[i].z, {1'b0, vecs[i].e});
         drain();
      end

      for (int i = 0; i < 1000; i++) begin
         if (i % 100 == 0) z = Q * 65536 - 1;
         else z = $urandom_range(0, Q * 65536 - 1);
         send(z, {1'b0, model(z)});
      end
      drain();

      lat_chk = 1'b0;
      bp_ph   = 0;
      bp_mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         z = $urandom_range(0, Q * 65536 - 1);
         send(z, {1'b0, model(z)});
      end
      drain();
      bp_mode = 1'b0;
      @(posedge clk);
      #1;

      lat_chk = 1'b1;
      for (int i = 0; i < 3; i++) begin
         z = $urandom_range(0, Q * 65536 - 1);
         send(z, {1'b0, model(z)});
      end
      pulse_reset();
      send(32'd65536, {1'b0, 16'd1});
      drain();
      repeat (8) @(posedge clk);
      #1;

      send(32'd805371904, 17'h10000);
      check("range_err_after_violation", range_err, chk_en);
      for (int i = 0; i < 10; i++) begin
         z = $urandom_range(0, Q * 65536 - 1);
         send(z, {1'b0, model(z)});
      end
      drain();
      check("range_err_sticky", range_err, chk_en);
      pulse_reset();
      check("range_err_cleared", range_err, 0);
      repeat (4) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keygen_mq_montyred.md
# keygen_mq_montyred

Pipelined Montgomery reducer for the Falcon keygen datapath. It consumes the raw 32-bit products delivered by the keygen DSP multiplier wrappers and returns the canonical residue z·2⁻¹⁶ mod Q in [0, Q). Q is 12289 by default. It sits directly downstream of the multiplier, closing the multiply/reduce loop used by NTT butterflies and polynomial pointwise products. A valid/ready handshake on both sides lets the consumer stall the pipe without losing data.

## Interface
- Q, 12289: modulus; must be odd and < 2¹⁵.
- Q0I, 12287: −Q⁻¹ mod 2¹⁶.
- DIN_WIDTH, 32: product input width.
- DOUT_WIDTH, 16: residue output width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  DIN_WIDTH  unsigned product z; precondition z < Q·2¹⁶.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  reducer accepts din this cycle.
- dout  out  DOUT_WIDTH  reduced residue.
- dout_valid  out  1  dout holds a result.
- dout_ready  in  1  consumer takes dout this cycle.
- range_err  out  1  sticky flag: a precondition violation was seen (see Configuration).

## Operation
- The pipeline has 4 registered stages, S1 to S4, and each stage has its own valid bit.
  - S1 captures z and computes m = (z[15:0]·Q0I) mod 2¹⁶, a 16×16 multiply truncated to 16 bits.
  - S2 carries z forward and computes t = m·Q, 31 bits unsigned.
  - S3 computes s = (z + t) >> 16. The add is 33 bits wide and must not truncate. The low 16 bits of z + t are zero by construction.
  - S4 computes r = s − Q. If r is negative, r += Q. The result is registered to dout.
- Global advance: adv = !S4.valid | dout_ready. When adv = 1, every stage shifts forward by one. When adv = 0, all stage registers and valid bits hold.
- din_ready = adv & !reset. A transfer occurs when din_valid & din_ready.
- A bubble, where din_valid = 0 while adv = 1, shifts a 0 valid bit into S1.
- dout and dout_valid come straight from S4 registers; there is no combinational path from din to dout.
- Once dout_valid is high, dout is held stable until the cycle in which dout_ready is high.
- Arithmetic rule: all intermediates are unsigned. Only the S4 subtract is evaluated signed, with 17 bits or more.

## Timing
- Latency: a transfer accepted in cycle n produces dout_valid in cycle n+4, provided dout_ready has been high throughout.
- Throughput is 1 result per cycle when dout_ready is held high.
- Backpressure: if dout_ready is low while S4.valid = 1, din_ready falls in the same cycle. Up to 4 results are held in flight and none are dropped or duplicated.
- Simultaneous events: when dout_ready = 1 and din_valid = 1 occur with a full pipe, the pipe advances and accepts new data in the same cycle.
- Reset: while reset is high, din_ready = 0. On the next edge, all valid bits, dout and range_err are cleared to 0. Products in flight are discarded, and no output handshake completes in a reset cycle.
- After reset deasserts, din_ready = 1 in the first cycle.

## Configuration
- KEYGEN_MQ_RED_RANGE_CHK_EN, when defined:
  - S1 compares each accepted z against Q·2¹⁶.
  - If z ≥ Q·2¹⁶, range_err is set one cycle after acceptance and stays set until reset.
  - dout for the violating item is still produced but is unspecified.
- Without the macro, range_err is tied to 0 and no comparator is built.

## Test plan
- Basic values with dout_ready held high. Expected results: 327680 → 5; 16736281 (4091²) → 4091; 12289 → 0; 0 → 0; 805306368 (12288·2¹⁶) → 12288. Each result appears exactly 4 cycles after acceptance.
- Streaming: 1000 back-to-back random z < Q·2¹⁶ → outputs in order, one per cycle, each matching the model (z·R⁻¹ mod Q with R = 2¹⁶), and every dout < 12289.
- Backpressure: stream 8 items while dout_ready toggles in a 1-on/3-off pattern → din_ready deasserts whenever S4 stalls, dout stays stable while stalled, and all 8 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert reset for 1 cycle while 3 items are in flight → dout_valid = 0 and din_ready = 0 during reset, and none of the 3 flushed results ever appears. Next, item 65536 → 1, four cycles after acceptance.
- Range check, built with KEYGEN_MQ_RED_RANGE_CHK_EN: z = 805371904 (Q·2¹⁶) → range_err = 1 one cycle after acceptance and still 1 after 10 further valid items. Reset clears it. Without the macro, range_err stays 0.
